dcm_clock_governor: RTL and testbench

Sequences frequency changes of the hashing-core DCM. Accepts a host-requested target multiplier, walks the applied multiplier toward it one step at a time with a settling dwell between steps, and backs off when the hashing cores report errors. It sits between the command decoder (target source) and the DCM programming engine, driving that engine through a req/ack handshake. It replaces direct multiplier writes so the core clock never jumps by more than one step.

---
 rtl/dcm_clock_governor_if.sv | 23 ++
 rtl/dcm_clock_governor.sv | 141 ++++++++++++++
 tb/tb_dcm_clock_governor.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcm_clock_governor_if.sv
// dcm_clock_governor_if: target, error, DCM programming handshake and
// status signals of the clock governor.
interface dcm_clock_governor_if;
    logic       target_valid;
    logic [7:0] target_mult;
    logic       hw_error;
    logic       prog_req;
    logic [7:0] prog_mult;
    logic       prog_ack;
    logic [7:0] current_mult;
    logic       busy;
    logic       throttled;

    modport master (
        input  target_valid, target_mult, hw_error, prog_ack,
        output prog_req, prog_mult, current_mult, busy, throttled
    );

    modport slave (
        output target_valid, target_mult, hw_error, prog_ack,
        input  prog_req, prog_mult, current_mult, busy, throttled
    );
endinterface

// File: rtl/dcm_clock_governor.sv
// dcm_clock_governor: walks the DCM multiplier one step at a time toward
// the target, with a dwell per step. Option macro: GOVERNOR_THROTTLE_EN.
module dcm_clock_governor #(
    parameter int MAXIMUM_MULTIPLIER = 64,
    parameter int MINIMUM_MULTIPLIER = 2,
    parameter int INITIAL_MULTIPLIER = 16,
    parameter int STEP_HOLD_CYCLES   = 1024,
    parameter int ERROR_THRESHOLD    = 4
) (
    input logic                  clk,
    input logic                  reset,
    dcm_clock_governor_if.master bus
);
    localparam logic [7:0] MAX_M = 8'(MAXIMUM_MULTIPLIER);
    localparam logic [7:0] MIN_M = 8'(MINIMUM_MULTIPLIER);
    localparam int INIT_C =
        (INITIAL_MULTIPLIER < MINIMUM_MULTIPLIER) ? MINIMUM_MULTIPLIER :
        (INITIAL_MULTIPLIER > MAXIMUM_MULTIPLIER) ? MAXIMUM_MULTIPLIER :
        INITIAL_MULTIPLIER;
    localparam logic [7:0]  INIT_M = 8'(INIT_C);
    localparam logic [15:0] HOLD   = 16'(STEP_HOLD_CYCLES);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;
    localparam logic [1:0] S_IDLE  = 2'd3;

    function automatic logic [7:0] clamp_mult(input logic [7:0] v);
        if (v < MIN_M) return MIN_M;
        if (v > MAX_M) return MAX_M;
        return v;
    endfunction

    logic [1:0]  state;
    logic [7:0]  target;
    logic [7:0]  ceiling;
    logic [7:0]  goal;
    logic [15:0] dwell;
    logic        step_req;
    logic [7:0]  step_mult;
    logic [7:0]  applied_mult;
    logic        busy_state;
    logic        throttle_flag;
    logic        dwell_exit;
    logic        acked;

    assign goal       = (target < ceiling) ? target : ceiling;
    assign dwell_exit = (state == S_DWELL) && (dwell <= 16'd1);
    assign acked      = step_req && bus.prog_ack;

    // Step sequencer: programming handshake, dwell timing, target capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            target       <= INIT_M;
            dwell        <= '0;
            step_req     <= 1'b0;
            step_mult    <= INIT_M;
            applied_mult <= '0;
            busy_state   <= 1'b1;
        end else begin
            if (bus.target_valid)
                target <= clamp_mult(bus.target_mult);
            unique case (state)
                S_INIT, S_REQ: begin
                    if (acked) begin
                        applied_mult <= step_mult;
                        step_req     <= 1'b0;
                        dwell        <= HOLD;
                        state        <= S_DWELL;
                    end else begin
                        step_req <= 1'b1;
                    end
                end
                S_DWELL: begin
                    if (dwell_exit) begin
                        state      <= S_IDLE;
                        busy_state <= 1'b0;
                    end else begin
                        dwell <= dwell - 16'd1;
                    end
                end
                S_IDLE: begin
                    if (goal != applied_mult) begin
                        step_mult  <= (goal > applied_mult) ?
                                      applied_mult + 8'd1 :
                                      applied_mult - 8'd1;
                        step_req   <= 1'b1;
                        state      <= S_REQ;
                        busy_state <= 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

`ifdef GOVERNOR_THROTTLE_EN
    logic [7:0] err_count;
    logic [8:0] err_next;
    logic       back_off;
    logic [7:0] backoff_ceiling;

    assign err_next = {1'b0, err_count} + 9'd1;
    assign back_off = bus.hw_error && (err_next >= 9'(ERROR_THRESHOLD));
    assign backoff_ceiling = (applied_mult > MIN_M) ?
                             applied_mult - 8'd1 : MIN_M;

    // Error window and ceiling back-off; a new target lifts the ceiling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count     <= '0;
            ceiling       <= MAX_M;
            throttle_flag <= 1'b0;
        end else if (bus.target_valid) begin
            err_count     <= '0;
            ceiling       <= MAX_M;
            throttle_flag <= 1'b0;
        end else if (back_off) begin
            err_count     <= '0;
            ceiling       <= backoff_ceiling;
            throttle_flag <= 1'b1;
        end else if (dwell_exit) begin
            err_count <= '0;
        end else if (bus.hw_error && err_count != 8'hFF) begin
            err_count <= err_next[7:0];
        end
    end
`else
    assign ceiling       = MAX_M;
    assign throttle_flag = 1'b0;
`endif

    assign bus.prog_req     = step_req;
    assign bus.prog_mult    = step_mult;
    assign bus.current_mult = applied_mult;
    assign bus.busy         = busy_state;
    assign bus.throttled    = throttle_flag;
endmodule

// File: tb/tb_dcm_clock_governor.sv
// tb_dcm_clock_governor: scoreboard of expected prog_mult values, served
// by an in-bench programming engine.
module tb_dcm_clock_governor;
    localparam int HOLD = 20;
`ifdef GOVERNOR_THROTTLE_EN
    localparam int BASE = 19;
`else
    localparam int BASE = 20;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    dcm_clock_governor_if gi();

    dcm_clock_governor #(
        .MAXIMUM_MULTIPLIER(64),
        .MINIMUM_MULTIPLIER(2),
        .INITIAL_MULTIPLIER(16),
        .STEP_HOLD_CYCLES(HOLD),
        .ERROR_THRESHOLD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(gi)
    );

    always #5 clk = ~clk;

    task automatic serve(input int delay, output logic [7:0] seen,
                         output bit ok, output bit stable);
        ok = 1'b0;
        stable = 1'b1;
        seen = '0;
        for (int i = 0; i < 500; i++) begin
            if (gi.prog_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        seen = gi.prog_mult;
        repeat (delay) begin
            @(negedge clk);
            if (gi.prog_req !== 1'b1 || gi.prog_mult !== seen)
                stable = 1'b0;
        end
        gi.prog_ack = 1'b1;
        @(negedge clk);
        gi.prog_ack = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (gi.busy !== 1'b0 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pop_exp(output logic [7:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 8'hxx;
    endtask

    task automatic drive_target(input logic [7:0] v);
        gi.target_valid = 1'b1;
        gi.target_mult = v;
        @(negedge clk);
        gi.target_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] seen, e;
        bit ok, st;
        int cyc;
        repeat (3) @(negedge clk);
        total++;
        if (gi.prog_req !== 1'b0 || gi.busy !== 1'b1 ||
            gi.current_mult !== 8'd0 || gi.throttled !== 1'b0 ||
            gi.prog_mult !== 8'd16) begin
            bad++;
            $display("FAIL reset_vals: req=%b busy=%b cur=%0d thr=%b pm=%0d want 0 1 0 0 16",
                     gi.prog_req, gi.busy, gi.current_mult,
                     gi.throttled, gi.prog_mult);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (gi.prog_req !== 1'b1) begin
            bad++;
            $display("FAIL init_req: prog_req=%b want 1", gi.prog_req);
        end
        exp_q.push_back(8'd16);
        serve(3, seen, ok, st);
        pop_exp(e);
        total++;
        if (!ok || !st || seen !== e) begin
            bad++;
            $display("FAIL init_mult: pm=%0d ok=%0d st=%0d want %0d",
                     seen, ok, st, e);
        end
        total++;
        if (gi.current_mult !== 8'd16) begin
            bad++;
            $display("FAIL init_cur: cur=%0d want 16", gi.current_mult);
        end
        wait_idle(cyc);
        total++;
        if (cyc != HOLD || gi.busy !== 1'b0) begin
            bad++;
            $display("FAIL init_dwell: cycles=%0d busy=%b want %0d 0",
                     cyc, gi.busy, HOLD);
        end
    endtask

    task automatic test_ramp_up();
        logic [7:0] seen, e;
        bit ok, st;
        int cyc;
        drive_target(8'd19);
        for (int m = 17; m <= 19; m++) exp_q.push_back(8'(m));
        for (int k = 0; k < 3; k++) begin
            serve(1, seen, ok, st);
            pop_exp(e);
            total++;
            if (!ok || seen !== e) begin
                bad++;
                $display("FAIL ramp_step%0d: pm=%0d ok=%0d want %0d",
                         k, seen, ok, e);
            end
            wait_idle(cyc);
            total++;
            if (cyc != HOLD) begin
                bad++;
                $display("FAIL ramp_dwell%0d: cycles=%0d want %0d",
                         k, cyc, HOLD);
            end
        end
        repeat (5) @(negedge clk);
        total++;
        if (gi.current_mult !== 8'd19 || gi.busy !== 1'b0 ||
            gi.prog_req !== 1'b0) begin
            bad++;
            $display("FAIL ramp_end: cur=%0d busy=%b req=%b want 19 0 0",
                     gi.current_mult, gi.busy, gi.prog_req);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] seen, e;
        bit ok, st;
        int cyc, errs, extra;
        drive_target(8'd200);
        for (int m = 20; m <= 64; m++) exp_q.push_back(8'(m));
        errs = 0;
        for (int k = 0; k < 45; k++) begin
            serve(0, seen, ok, st);
            pop_exp(e);
            if (!ok || seen !== e || seen > 8'd64) errs++;
            wait_idle(cyc);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (gi.prog_req !== 1'b0) extra++;
        end
        total++;
        if (errs != 0 || extra != 0 || gi.current_mult !== 8'd64) begin
            bad++;
            $display("FAIL clamp_hi: step_errs=%0d extra_req=%0d cur=%0d want 0 0 64",
                     errs, extra, gi.current_mult);
        end
        drive_target(8'd0);
        for (int m = 63; m >= 2; m--) exp_q.push_back(8'(m));
        errs = 0;
        for (int k = 0; k < 62; k++) begin
            serve(0, seen, ok, st);
            pop_exp(e);
            if (!ok || seen !== e || seen < 8'd2) errs++;
            wait_idle(cyc);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (gi.prog_req !== 1'b0) extra++;
        end
        total++;
        if (errs != 0 || extra != 0 || gi.current_mult !== 8'd2) begin
            bad++;
            $display("FAIL clamp_lo: step_errs=%0d extra_req=%0d cur=%0d want 0 0 2",
                     errs, extra, gi.current_mult);
        end
    endtask

    task automatic test_throttle();
        logic [7:0] seen, e;
        bit ok, st;
        int cyc, errs, extra;
        drive_target(8'd20);
        for (int m = 3; m <= 20; m++) exp_q.push_back(8'(m));
        errs = 0;
        for (int k = 0; k < 17; k++) begin
            serve(0, seen, ok, st);
            pop_exp(e);
            if (!ok || seen !== e) errs++;
            wait_idle(cyc);
        end
        serve(0, seen, ok, st);
        pop_exp(e);
        if (!ok || seen !== e) errs++;
        total++;
        if (errs != 0 || gi.current_mult !== 8'd20) begin
            bad++;
            $display("FAIL thr_ramp: step_errs=%0d cur=%0d want 0 20",
                     errs, gi.current_mult);
        end
        repeat (4) begin
            gi.hw_error = 1'b1;
            @(negedge clk);
            gi.hw_error = 1'b0;
            @(negedge clk);
        end
        total++;
        if (gi.throttled !== (BASE == 19 ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL thr_flag: throttled=%b want %b",
                     gi.throttled, (BASE == 19));
        end
        wait_idle(cyc);
        if (BASE == 19) begin
            exp_q.push_back(8'd19);
            serve(1, seen, ok, st);
            pop_exp(e);
            total++;
            if (!ok || seen !== e) begin
                bad++;
                $display("FAIL thr_step: pm=%0d ok=%0d want %0d", seen, ok, e);
            end
            wait_idle(cyc);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (gi.prog_req !== 1'b0) extra++;
        end
        total++;
        if (extra != 0 || gi.current_mult !== 8'(BASE)) begin
            bad++;
            $display("FAIL thr_settle: extra_req=%0d cur=%0d want 0 %0d",
                     extra, gi.current_mult, BASE);
        end
    endtask

    task automatic test_slow_ack();
        logic [7:0] seen, e;
        bit ok;
        int cyc, unstable, errs;
        drive_target(8'd30);
        total++;
        if (gi.throttled !== 1'b0) begin
            bad++;
            $display("FAIL slow_thr_clear: throttled=%b want 0", gi.throttled);
        end
        exp_q.push_back(8'(BASE + 1));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (gi.prog_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        seen = gi.prog_mult;
        pop_exp(e);
        total++;
        if (!ok || seen !== e) begin
            bad++;
            $display("FAIL slow_first: pm=%0d ok=%0d want %0d", seen, ok, e);
        end
        unstable = 0;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                gi.target_valid = 1'b1;
                gi.target_mult = 8'd10;
            end
            if (i == 251) gi.target_valid = 1'b0;
            @(negedge clk);
            if (gi.prog_req !== 1'b1 || gi.prog_mult !== seen) unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL slow_stable: unstable_cycles=%0d want 0", unstable);
        end
        gi.prog_ack = 1'b1;
        @(negedge clk);
        gi.prog_ack = 1'b0;
        total++;
        if (gi.current_mult !== 8'(BASE + 1) || gi.prog_req !== 1'b0) begin
            bad++;
            $display("FAIL slow_done: cur=%0d req=%b want %0d 0",
                     gi.current_mult, gi.prog_req, BASE + 1);
        end
        wait_idle(cyc);
        for (int m = BASE; m >= 10; m--) exp_q.push_back(8'(m));
        errs = 0;
        for (int k = 0; k < BASE - 9; k++) begin
            serve(2, seen, ok, unstable[0]);
            pop_exp(e);
            if (!ok || seen !== e) errs++;
            wait_idle(cyc);
        end
        total++;
        if (errs != 0 || gi.current_mult !== 8'd10) begin
            bad++;
            $display("FAIL slow_ramp_down: step_errs=%0d cur=%0d want 0 10",
                     errs, gi.current_mult);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seen, e;
        bit ok, st;
        int cyc;
        drive_target(8'd14);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (gi.prog_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok || gi.prog_mult !== 8'd11) begin
            bad++;
            $display("FAIL mid_req: ok=%0d pm=%0d want 1 11", ok, gi.prog_mult);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (gi.prog_req !== 1'b0 || gi.current_mult !== 8'd0 ||
            gi.busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_async: req=%b cur=%0d busy=%b want 0 0 1",
                     gi.prog_req, gi.current_mult, gi.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(8'd16);
        @(negedge clk);
        total++;
        if (gi.prog_req !== 1'b1 || gi.current_mult !== 8'd0) begin
            bad++;
            $display("FAIL mid_reinit: req=%b cur=%0d want 1 0",
                     gi.prog_req, gi.current_mult);
        end
        serve(3, seen, ok, st);
        pop_exp(e);
        total++;
        if (!ok || !st || seen !== e || gi.current_mult !== 8'd16) begin
            bad++;
            $display("FAIL mid_ack: pm=%0d ok=%0d cur=%0d want %0d 1 16",
                     seen, ok, gi.current_mult, e);
        end
        wait_idle(cyc);
        total++;
        if (cyc != HOLD || gi.busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_dwell: cycles=%0d busy=%b want %0d 0",
                     cyc, gi.busy, HOLD);
        end
    endtask

    initial begin
        gi.target_valid = 1'b0;
        gi.target_mult = '0;
        gi.hw_error = 1'b0;
        gi.prog_ack = 1'b0;
        test_reset();
        test_ramp_up();
        test_clamp();
        test_throttle();
        test_slow_ack();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
